// File: rtl/pong_pp_pkg.sv
// Shared types and constants for the Pong power-up engine.
//   pp_mode_t    : pickup/effect type, also the bit index of effect_active
//   slot_state_t : per-slot FSM state
//   PP_COLOR     : RGB332 colour per mode, indexed by pp_mode_t
//   slot_t       : registered contents of one pickup slot
package pong_pp_pkg;

    typedef enum logic [1:0] {
        SHRINK = 2'd0,
        BOOST  = 2'd1,
        MULTI  = 2'd2,
        SHIELD = 2'd3
    } pp_mode_t;

    typedef enum logic {
        SLOT_FREE = 1'b0,
        SLOT_LIVE = 1'b1
    } slot_state_t;

    localparam int PP_AGE_W = 16;

    // [0]=SHRINK red, [1]=BOOST green, [2]=MULTI blue, [3]=SHIELD yellow
    localparam logic [3:0][7:0] PP_COLOR = {8'hFC, 8'h03, 8'h1C, 8'hE0};

    typedef struct packed {
        slot_state_t           live;
        logic [10:0]           x;
        logic [9:0]            y;
        pp_mode_t              mode;
        logic [PP_AGE_W-1:0]   age;
    } slot_t;

endpackage

// File: rtl/power_up_manager_if.sv
// Signal bundle between the power-up manager and its neighbours
// (random source, ball logic, VGA timing/mixer).
//   master : drives frame_tick, spawn request, random values, ball and scan position
//   slave  : the manager; returns spawn handshake, effect events and pickup pixel
interface power_up_manager_if;

    logic                    frame_tick;
    logic                    spawn;
    logic [10:0]             randx;
    logic [9:0]              randy;
    pong_pp_pkg::pp_mode_t   randmode;
    logic [10:0]             ball_x;
    logic [9:0]              ball_y;
    logic [10:0]             hcount;
    logic [9:0]              vcount;
    logic                    spawn_ack;
    logic                    randop;
    logic                    full;
    logic                    effect_valid;
    pong_pp_pkg::pp_mode_t   effect_mode;
    logic [3:0]              effect_active;
    logic [7:0]              pixel;

    modport master (
        output frame_tick, spawn, randx, randy, randmode, ball_x, ball_y, hcount, vcount,
        input  spawn_ack, randop, full, effect_valid, effect_mode, effect_active, pixel
    );

    modport slave (
        input  frame_tick, spawn, randx, randy, randmode, ball_x, ball_y, hcount, vcount,
        output spawn_ack, randop, full, effect_valid, effect_mode, effect_active, pixel
    );

endinterface

// File: rtl/pp_slot.sv
// One pickup slot: FREE/LIVE FSM, saturating age counter, ball-overlap and
// pixel-coverage compares.
//   clk, reset        : clock, synchronous active-high reset
//   frame_tick        : ages the slot; despawn after LIFETIME frames
//   load, load_*      : occupy a FREE slot with a new pickup
//   eat               : slot chosen for pickup this cycle, freed at the edge
//   ball_x/ball_y     : ball top-left
//   hcount/vcount     : scan position for pixel coverage
//   show_late         : when low, pickups in the last quarter of life are hidden
//   live, mode        : registered slot state
//   hit               : live and overlapping the ball
//   covers            : live, visible and containing (hcount, vcount)
module pp_slot
    import pong_pp_pkg::*;
#(
    parameter int WIDTH     = 20,
    parameter int HEIGHT    = 20,
    parameter int BALL_SIZE = 16,
    parameter int LIFETIME  = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        load,
    input  logic [10:0] load_x,
    input  logic [9:0]  load_y,
    input  pp_mode_t    load_mode,
    input  logic        eat,
    input  logic [10:0] ball_x,
    input  logic [9:0]  ball_y,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        show_late,
    output logic        live,
    output pp_mode_t    mode,
    output logic        hit,
    output logic        covers
);

    slot_t slot_q, slot_d;

    // 12-bit operands so box edges near the screen limit cannot wrap
    logic [11:0] px, py, bx, by, hx, vy;
    logic        late;

    assign px = {1'b0, slot_q.x};
    assign py = {2'b0, slot_q.y};
    assign bx = {1'b0, ball_x};
    assign by = {2'b0, ball_y};
    assign hx = {1'b0, hcount};
    assign vy = {2'b0, vcount};

    always_comb begin
        slot_d = slot_q;
        if (slot_q.live == SLOT_FREE) begin
            if (load) begin
                slot_d.live = SLOT_LIVE;
                slot_d.x    = load_x;
                slot_d.y    = load_y;
                slot_d.mode = load_mode;
                slot_d.age  = '0;
            end
        end else begin
            if (frame_tick && slot_q.age != '1)
                slot_d.age = slot_q.age + 1'b1;
            if (eat || (frame_tick && slot_q.age == PP_AGE_W'(LIFETIME - 1)))
                slot_d.live = SLOT_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) slot_q <= '0;
        else       slot_q <= slot_d;
    end

    assign live = (slot_q.live == SLOT_LIVE);
    assign mode = slot_q.mode;

    assign hit = live
              && (bx < px + 12'(WIDTH))  && (px < bx + 12'(BALL_SIZE))
              && (by < py + 12'(HEIGHT)) && (py < by + 12'(BALL_SIZE));

    assign late = (slot_q.age >= PP_AGE_W'(3 * LIFETIME / 4));

    assign covers = live && (!late || show_late)
                 && (hx >= px) && (hx < px + 12'(WIDTH))
                 && (vy >= py) && (vy < py + 12'(HEIGHT));

endmodule

// File: rtl/power_up_manager.sv
// Multi-slot power-up engine: spawns pickups into free slots, despawns them
// after LIFETIME frames, turns ball contact into effect events, times each
// effect for EFFECT_DUR frames and renders pickup pixels.
// Optional feature macro: POWER_UP_BLINK_EN -- pickups in the last quarter of
// their life blink with frame-counter bit 3; without it they render solid.
//   clk, reset : pixel clock, synchronous active-high reset
//   bus        : power_up_manager_if.slave (frame_tick, spawn/rand inputs,
//                ball and scan position in; spawn_ack, randop, full,
//                effect_valid/effect_mode, effect_active, pixel out)
module power_up_manager
    import pong_pp_pkg::*;
#(
    parameter int N_SLOTS    = 4,
    parameter int WIDTH      = 20,
    parameter int HEIGHT     = 20,
    parameter int BALL_SIZE  = 16,
    parameter int LIFETIME   = 600,
    parameter int EFFECT_DUR = 300,
    parameter int TW         = 10
) (
    input  logic                clk,
    input  logic                reset,
    power_up_manager_if.slave   bus
);

    logic [N_SLOTS-1:0] live_v, hit_v, cover_v, load_v, eat_v;
    pp_mode_t           mode_v [N_SLOTS];
    logic               full, spawn_ack, show_late;
    logic               found_free, found_hit, found_pix;
    pp_mode_t           hit_mode;
    logic [7:0]         pixel_c;

    logic               randop_q, randop_d;
    logic               effect_valid_q, effect_valid_d;
    pp_mode_t           effect_mode_q, effect_mode_d;
    logic [3:0][TW-1:0] timer_q, timer_d;

`ifdef POWER_UP_BLINK_EN
    logic [3:0] frame_cnt_q, frame_cnt_d;
    assign frame_cnt_d = bus.frame_tick ? frame_cnt_q + 4'd1 : frame_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) frame_cnt_q <= '0;
        else       frame_cnt_q <= frame_cnt_d;
    end
    assign show_late = frame_cnt_q[3];
`else
    assign show_late = 1'b1;
`endif

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        pp_slot #(
            .WIDTH     (WIDTH),
            .HEIGHT    (HEIGHT),
            .BALL_SIZE (BALL_SIZE),
            .LIFETIME  (LIFETIME)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (bus.frame_tick),
            .load       (load_v[g]),
            .load_x     (bus.randx),
            .load_y     (bus.randy),
            .load_mode  (bus.randmode),
            .eat        (eat_v[g]),
            .ball_x     (bus.ball_x),
            .ball_y     (bus.ball_y),
            .hcount     (bus.hcount),
            .vcount     (bus.vcount),
            .show_late  (show_late),
            .live       (live_v[g]),
            .mode       (mode_v[g]),
            .hit        (hit_v[g]),
            .covers     (cover_v[g])
        );
    end

    // Free-slot choice uses registered state, so a slot freed on this edge
    // only becomes available to spawn on the following cycle.
    assign full      = &live_v;
    assign spawn_ack = bus.spawn && !full && !reset;

    // Lowest-index priority encoders for spawn target, pickup and pixel.
    always_comb begin
        load_v     = '0;
        eat_v      = '0;
        hit_mode   = SHRINK;
        pixel_c    = '0;
        found_free = 1'b0;
        found_hit  = 1'b0;
        found_pix  = 1'b0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!live_v[i] && !found_free) begin
                load_v[i]  = spawn_ack;
                found_free = 1'b1;
            end
            if (hit_v[i] && !found_hit) begin
                eat_v[i]  = 1'b1;
                hit_mode  = mode_v[i];
                found_hit = 1'b1;
            end
            if (cover_v[i] && !found_pix) begin
                pixel_c   = PP_COLOR[mode_v[i]];
                found_pix = 1'b1;
            end
        end
    end

    always_comb begin
        randop_d       = spawn_ack;
        effect_valid_d = found_hit;
        effect_mode_d  = found_hit ? hit_mode : effect_mode_q;
        timer_d        = timer_q;
        for (int unsigned m = 0; m < 4; m++) begin
            // A re-pick of an active mode restarts its duration, it does not add.
            if (effect_valid_q && effect_mode_q == pp_mode_t'(m[1:0]))
                timer_d[m] = TW'(EFFECT_DUR);
            else if (bus.frame_tick && timer_q[m] != '0)
                timer_d[m] = timer_q[m] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            randop_q       <= 1'b0;
            effect_valid_q <= 1'b0;
            effect_mode_q  <= SHRINK;
            timer_q        <= '0;
        end else begin
            randop_q       <= randop_d;
            effect_valid_q <= effect_valid_d;
            effect_mode_q  <= effect_mode_d;
            timer_q        <= timer_d;
        end
    end

    always_comb begin
        bus.effect_active = '0;
        for (int unsigned m = 0; m < 4; m++)
            bus.effect_active[m] = (timer_q[m] != '0);
    end

    assign bus.spawn_ack    = spawn_ack;
    assign bus.full         = full;
    assign bus.randop       = randop_q;
    assign bus.effect_valid = effect_valid_q;
    assign bus.effect_mode  = effect_mode_q;
    assign bus.pixel        = pixel_c;

endmodule

// File: tb/tb_power_up_manager.sv
module tb_power_up_manager;
    import pong_pp_pkg::*;

    localparam int N    = 4;
    localparam int W    = 20;
    localparam int H    = 20;
    localparam int B    = 16;
    localparam int LIFE = 600;
    localparam int DUR  = 300;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    power_up_manager_if bus();

    power_up_manager #(
        .N_SLOTS    (N),
        .WIDTH      (W),
        .HEIGHT     (H),
        .BALL_SIZE  (B),
        .LIFETIME   (LIFE),
        .EFFECT_DUR (DUR),
        .TW         (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers per pickup and per effect.
    int  m_live [N];
    int  m_x    [N];
    int  m_y    [N];
    int  m_mode [N];
    int  m_age  [N];
    int  m_left [4];
    int  m_ev, m_em, m_randop, m_frames;
    logic [7:0] col_tab [4] = '{8'hE0, 8'h1C, 8'h03, 8'hFC};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit touches_ball(int i);
        int bx = int'(bus.ball_x);
        int by = int'(bus.ball_y);
        return m_live[i] != 0 && bx < m_x[i] + W && m_x[i] < bx + B
                              && by < m_y[i] + H && m_y[i] < by + B;
    endfunction

    function automatic bit shown(int i);
`ifdef POWER_UP_BLINK_EN
        return m_age[i] < (3 * LIFE) / 4 || ((m_frames / 8) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_live[i] = 0; m_x[i] = 0; m_y[i] = 0; m_mode[i] = 0; m_age[i] = 0;
        end
        for (int m = 0; m < 4; m++) m_left[m] = 0;
        m_ev = 0; m_em = 0; m_randop = 0; m_frames = 0;
    endfunction

    // Called at the negedge with inputs applied: check outputs, advance model
    // by one clock, return at the next negedge.
    task automatic cycle();
        int occupied, ack_e, pix_e, act_e, hit, slot, tick;
        #1;
        occupied = 0;
        for (int i = 0; i < N; i++) occupied += m_live[i];
        ack_e = (!reset && bus.spawn && occupied < N) ? 1 : 0;
        pix_e = 0;
        for (int i = N - 1; i >= 0; i--)
            if (m_live[i] != 0 && shown(i)
                && int'(bus.hcount) >= m_x[i] && int'(bus.hcount) < m_x[i] + W
                && int'(bus.vcount) >= m_y[i] && int'(bus.vcount) < m_y[i] + H)
                pix_e = col_tab[m_mode[i]];
        act_e = 0;
        for (int m = 0; m < 4; m++) if (m_left[m] > 0) act_e += (1 << m);

        check("full",          32'(bus.full),          32'(occupied == N));
        check("spawn_ack",     32'(bus.spawn_ack),     32'(ack_e));
        check("randop",        32'(bus.randop),        32'(m_randop));
        check("pixel",         32'(bus.pixel),         32'(pix_e));
        check("effect_valid",  32'(bus.effect_valid),  32'(m_ev));
        check("effect_mode",   32'(bus.effect_mode),   32'(m_em));
        check("effect_active", 32'(bus.effect_active), 32'(act_e));

        if (reset) begin
            model_clear();
        end else begin
            tick = bus.frame_tick ? 1 : 0;
            hit = -1;
            for (int i = N - 1; i >= 0; i--) if (touches_ball(i)) hit = i;
            slot = -1;
            for (int i = N - 1; i >= 0; i--) if (m_live[i] == 0) slot = i;
            for (int m = 0; m < 4; m++) begin
                if (m_ev != 0 && m_em == m) m_left[m] = DUR;
                else if (tick != 0 && m_left[m] > 0) m_left[m]--;
            end
            m_ev = (hit >= 0) ? 1 : 0;
            if (hit >= 0) m_em = m_mode[hit];
            m_randop = ack_e;
            for (int i = 0; i < N; i++) begin
                if (m_live[i] != 0) begin
                    if (i == hit || (tick != 0 && m_age[i] + 1 >= LIFE)) m_live[i] = 0;
                    else if (tick != 0 && m_age[i] < 65535) m_age[i]++;
                end
            end
            if (ack_e != 0) begin
                m_live[slot] = 1;
                m_x[slot]    = int'(bus.randx);
                m_y[slot]    = int'(bus.randy);
                m_mode[slot] = int'(bus.randmode);
                m_age[slot]  = 0;
            end
            if (tick != 0) m_frames++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.frame_tick = 1'b1; cycle();
            bus.frame_tick = 1'b0; cycle();
        end
    endtask

    task automatic spawn_at(input int x, input int y, input int mode);
        bus.spawn = 1'b1;
        bus.randx = 11'(x); bus.randy = 10'(y); bus.randmode = pp_mode_t'(mode);
        cycle();
        bus.spawn = 1'b0;
    endtask

    task automatic ball_at(input int x, input int y);
        bus.ball_x = 11'(x); bus.ball_y = 10'(y);
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.spawn = 1'b0;
        bus.randx = '0; bus.randy = '0; bus.randmode = SHRINK;
        bus.ball_x = '0; bus.ball_y = '0; bus.hcount = '0; bus.vcount = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();                                   // reset state
        reset = 1'b0;
        cycle();

        // First pickup and its pixel box edges
        spawn_at(700, 500, 3);
        bus.hcount = 11'd700; bus.vcount = 10'd500; cycle();
        bus.hcount = 11'd719; bus.vcount = 10'd519; cycle();
        bus.hcount = 11'd720; bus.vcount = 10'd500; cycle();
        bus.hcount = 11'd700; bus.vcount = 10'd520; cycle();

        // Fill remaining slots, then one refused spawn
        for (int k = 0; k < N; k++)
            spawn_at($urandom_range(800, 1000), $urandom_range(600, 700), $urandom_range(0, 3));
        cycle();

        // Eat slot 0 (SHIELD)
        ball_at(705, 505); cycle(); cycle(); cycle();
        ball_at(0, 0);
        frames(100);

        // Re-pick SHIELD: duration restarts
        spawn_at(300, 300, 3);
        ball_at(305, 305); cycle(); cycle(); cycle();
        ball_at(0, 0);
        frames(302);
        frames(260);                               // untouched pickups despawn

        // Two overlaps in one cycle: slot1 then slot2
        spawn_at(900, 650, 0);
        spawn_at(400, 200, 1);
        spawn_at(410, 205, 2);
        ball_at(405, 205); cycle(); cycle(); cycle(); cycle();
        ball_at(0, 0); cycle();

        // Randomized play around a small area
        for (int c = 0; c < 4000; c++) begin
            bus.spawn      = ($urandom_range(0, 3) == 0);
            bus.randx      = 11'($urandom_range(200, 300));
            bus.randy      = 10'($urandom_range(200, 300));
            bus.randmode   = pp_mode_t'($urandom_range(0, 3));
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.hcount     = 11'($urandom_range(190, 330));
            bus.vcount     = 10'($urandom_range(190, 330));
            if (c % 8 == 0) ball_at($urandom_range(150, 320), $urandom_range(150, 320));
            cycle();
        end
        bus.frame_tick = 1'b0;
        ball_at(0, 0);
        cycle();

        // Reset in the middle of an active effect
        spawn_at(500, 400, 1);
        ball_at(502, 402); cycle(); cycle(); cycle();
        bus.hcount = 11'd950; bus.vcount = 10'd660;
        frames(3);
        reset = 1'b1; bus.spawn = 1'b1; cycle();
        reset = 1'b0; bus.spawn = 1'b0; cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
